data_sram_ctrl: RTL and testbench

Responder end of the core's data-memory port (ce/we/addr/wdata in, rdata out). It drives an external asynchronous single-port SRAM.
- Reads are served combinationally in the same cycle, which matches the core's single-cycle MEM stage.
- Writes run a multi-cycle SRAM write FSM. busy_o is asserted so the pipeline stalls until the SRAM write pulse completes.
- Sits between the core's ram_* ports and the board SRAM pins; busy_o feeds the stall controller.

---
 rtl/data_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_data_sram_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_ctrl.sv
// Data-memory port responder driving an asynchronous single-port SRAM: same-cycle reads, stalled multi-cycle writes.
// Optional build macro SRAM_WR_VERIFY_EN adds a read-back VERIFY state and the sticky wr_err_o output.
//
// state  | meaning
// IDLE   | serve reads combinationally, accept a write request
// SETUP  | address/data driven, we_n still high
// PULSE  | we_n low for WR_CYCLES cycles
// HOLD   | we_n released, data still driven
// VERIFY | read back the written word (SRAM_WR_VERIFY_EN only)
// DONE   | stall released; the still-present write request is not re-accepted
module data_sram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef SRAM_WR_VERIFY_EN
  ,
  output logic              wr_err_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_VERIFY, S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WR_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   w_word;
  logic                w_accept;
  logic                w_unused;

  assign w_word    = addr_i[ADDR_W+1:2];
  assign w_unused  = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign w_accept  = (r_state == S_IDLE) && ce_i && we_i;
  assign sram_dq_o = r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr <= w_word;
        r_data <= data_i;
      end
    end
  end

`ifdef SRAM_WR_VERIFY_EN
  logic r_wr_err;
  always_ff @(posedge clk) begin
    if (!rst)
      r_wr_err <= 1'b0;
    else if (r_state == S_VERIFY && sram_dq_i != r_data)
      r_wr_err <= 1'b1;
  end
  assign wr_err_o = r_wr_err;
`endif

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    busy_o      = 1'b0;
    data_o      = '0;
    sram_addr_o = r_addr;
    case (r_state)
      S_IDLE: begin
        sram_addr_o = w_word;
        if (ce_i && we_i) begin
          busy_o = 1'b1;
          w_next = S_SETUP;
        end else if (ce_i) begin
          sram_ce_n = 1'b0;
          sram_oe_n = 1'b0;
          data_o    = sram_dq_i;
        end
      end
      S_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        busy_o     = 1'b1;
        w_cnt_next = CNT_INIT;
        w_next     = S_PULSE;
      end
      S_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        busy_o     = 1'b1;
        if (r_cnt == 4'd0)
          w_next = S_HOLD;
        else
          w_cnt_next = r_cnt - 4'd1;
      end
      S_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        busy_o     = 1'b1;
`ifdef SRAM_WR_VERIFY_EN
        w_next     = S_VERIFY;
`else
        w_next     = S_DONE;
`endif
      end
      S_VERIFY: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        busy_o    = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // reset masks every control combinationally, before the first edge lands
    if (!rst) begin
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_dq_oe = 1'b0;
      busy_o     = 1'b0;
      data_o     = '0;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: two instances (WR_CYCLES=2 and 4), each with a behavioural SRAM model.
// Build with SRAM_WR_VERIFY_EN defined to include the read-back check scenario.
module tb_data_sram_ctrl;
`ifdef SRAM_WR_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  ce, we, busy, dq_oe, ce_n, oe_n, we_n;
  logic [31:0] addr[2], wdata[2], rdata[2], dq_o[2], dq_i[2];
  logic [17:0] saddr[2];
  logic [1:0]  wr_err;
  logic        stuck = 1'b0;
  logic        seeded0 = 1'b0, seeded1 = 1'b0;
  logic [31:0] mem0[256], mem1[256], ref0[256], ref1[256];
  int          total = 0, bad = 0;

  data_sram_ctrl #(.DATA_W(32), .ADDR_W(18), .WR_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]), .data_i(wdata[0]),
    .data_o(rdata[0]), .busy_o(busy[0]), .sram_addr_o(saddr[0]), .sram_dq_i(dq_i[0]),
    .sram_dq_o(dq_o[0]), .sram_dq_oe(dq_oe[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0])
`ifdef SRAM_WR_VERIFY_EN
    , .wr_err_o(wr_err[0])
`endif
  );

  data_sram_ctrl #(.DATA_W(32), .ADDR_W(18), .WR_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]), .data_i(wdata[1]),
    .data_o(rdata[1]), .busy_o(busy[1]), .sram_addr_o(saddr[1]), .sram_dq_i(dq_i[1]),
    .sram_dq_o(dq_o[1]), .sram_dq_oe(dq_oe[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1])
`ifdef SRAM_WR_VERIFY_EN
    , .wr_err_o(wr_err[1])
`endif
  );
`ifndef SRAM_WR_VERIFY_EN
  assign wr_err = 2'b00;
`endif

  // asynchronous SRAM models: write while ce_n/we_n low with data driven, read while ce_n/oe_n low
  always @(posedge clk) begin
    if (!seeded0) begin
      for (int k = 0; k < 256; k++) mem0[k] <= 32'hC0DE_0000 | 32'(k);
      seeded0 <= 1'b1;
    end else if (!ce_n[0] && !we_n[0] && dq_oe[0])
      mem0[saddr[0][7:0]] <= dq_o[0] & ~{31'b0, stuck};
  end
  always @(posedge clk) begin
    if (!seeded1) begin
      for (int k = 0; k < 256; k++) mem1[k] <= 32'hC0DE_0000 | 32'(k);
      seeded1 <= 1'b1;
    end else if (!ce_n[1] && !we_n[1] && dq_oe[1])
      mem1[saddr[1][7:0]] <= dq_o[1];
  end
  assign dq_i[0] = (!ce_n[0] && !oe_n[0]) ? mem0[saddr[0][7:0]] : 32'h0;
  assign dq_i[1] = (!ce_n[1] && !oe_n[1]) ? mem1[saddr[1][7:0]] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int s, input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce[s] = c; we[s] = w; addr[s] = a; wdata[s] = d;
  endtask

  // expected per-cycle activity, cycle 0 = accept
  function automatic logic [15:0] busy_mask(input int wc);
    return 16'((1 << (wc + 3 + V)) - 1);
  endfunction
  function automatic logic [15:0] we_mask(input int wc);
    return 16'(((1 << wc) - 1) << 2);
  endfunction
  function automatic logic [15:0] oe_mask(input int wc);
    return 16'(((1 << (wc + 2)) - 1) << 1);
  endfunction

  // request held until the cycle the stall drops; returns at #1 after that edge, request still asserted
  task automatic write_chk(input int s, input int wc, input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [15:0] bm, wm, om;
    logic        ok, done;
    bm = '0; wm = '0; om = '0; ok = 1'b1;
    drv(s, 1'b1, 1'b1, a, d);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bm[i] = busy[s]; wm[i] = ~we_n[s]; om[i] = dq_oe[s];
      if (dq_oe[s] && dq_o[s] !== d) ok = 1'b0;
      if (!ce_n[s] && saddr[s] !== a[19:2]) ok = 1'b0;
      if (dq_oe[s] && !oe_n[s]) ok = 1'b0;
      if (rdata[s] !== 32'h0) ok = 1'b0;
      done = !busy[s];
      @(posedge clk); #1;
      if (done) break;
    end
    chk({tag, "_busy"}, 64'(bm), 64'(busy_mask(wc)));
    chk({tag, "_we"}, 64'(wm), 64'(we_mask(wc)));
    chk({tag, "_dqoe"}, 64'(om), 64'(oe_mask(wc)));
    chk({tag, "_bus"}, 64'(ok), 64'd1);
    if (s == 0) ref0[a[9:2]] = d & ~{31'b0, stuck};
    else        ref1[a[9:2]] = d;
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input string tag);
    logic [31:0] exp;
    exp = (s == 0) ? ref0[a[9:2]] : ref1[a[9:2]];
    drv(s, 1'b1, 1'b0, a, 32'h0);
    @(negedge clk);
    chk({tag, "_data"}, 64'(rdata[s]), 64'(exp));
    chk({tag, "_ctl"}, {busy[s], oe_n[s], ce_n[s], we_n[s], dq_oe[s]}, 64'b00010);
    chk({tag, "_addr"}, 64'(saddr[s]), 64'(a[19:2]));
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input int s, input string tag);
    drv(s, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk(tag, {busy[s], ce_n[s], oe_n[s], we_n[s], dq_oe[s], 32'(rdata[s])}, {5'b01110, 32'h0});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, d;
    int          op;
    for (int k = 0; k < 256; k++) begin
      ref0[k] = 32'hC0DE_0000 | 32'(k);
      ref1[k] = 32'hC0DE_0000 | 32'(k);
    end
    rst = 1'b0;
    drv(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_forced", {busy[0], ce_n[0], oe_n[0], we_n[0], dq_oe[0], 32'(rdata[0])}, {5'b01110, 32'h0});
    @(posedge clk); #1;
    rst = 1'b1;
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_state", {busy[0], ce_n[0], we_n[0], dq_oe[0], dq_o[0]}, {4'b0110, 32'h0});
    chk("rst_err", 64'(wr_err), 64'd0);
    @(posedge clk); #1;

    // plan 1 and 2
    write_chk(0, 2, 32'h100, 32'hDEAD_BEEF, "t1");
    chk("t1_mem", 64'(mem0[8'h40]), 64'hDEAD_BEEF);
    idle_chk(0, "t1_noreaccept");
    idle_chk(0, "t1_idle");
    do_read(0, 32'h100, "t2");

    // plan 3: second write in the cycle right after DONE
    write_chk(0, 2, 32'h0, 32'h1, "t3a");
    write_chk(0, 2, 32'h4, 32'h2, "t3b");
    idle_chk(0, "t3_idle");
    chk("t3_mem", {mem0[0], mem0[1]}, {32'h1, 32'h2});

    // high word address exercises the upper address bits
    write_chk(0, 2, 32'h000F_FE03, 32'h5A5A_0F0F, "hi");
    do_read(0, 32'h000F_FE00, "hi_rd");

    // plan 4: reset in the first PULSE cycle
    drv(0, 1'b1, 1'b1, 32'h320, 32'h1234_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_forced", {busy[0], ce_n[0], we_n[0], dq_oe[0]}, 64'b0110);
    @(posedge clk); #1;
    rst = 1'b1;
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_idle", {busy[0], ce_n[0], we_n[0], dq_oe[0], dq_o[0]}, {4'b0110, 32'h0});
    @(posedge clk); #1;
    do_read(0, 32'h100, "t4_rd");

    // plan 5: WR_CYCLES=4 instance
    write_chk(1, 4, 32'h40, 32'hA5A5_A5A5, "t5");
    chk("t5_mem", 64'(mem1[8'h10]), 64'hA5A5_A5A5);
    idle_chk(1, "t5_idle");
    do_read(1, 32'h40, "t5_rd");

    // randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      a  = {22'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      if (op == 0)      write_chk(0, 2, a, d, "rnd_wr");
      else if (op == 1) do_read(0, a, "rnd_rd");
      else              idle_chk(0, "rnd_idle");
    end
    idle_chk(0, "rnd_end");

`ifdef SRAM_WR_VERIFY_EN
    // plan 6: bit 0 stuck at 0 in the SRAM model
    chk("t6_pre", 64'(wr_err[0]), 64'd0);
    stuck = 1'b1;
    write_chk(0, 2, 32'h8, 32'h3, "t6");
    stuck = 1'b0;
    chk("t6_err", 64'(wr_err[0]), 64'd1);
    idle_chk(0, "t6_idle");
    chk("t6_sticky", 64'(wr_err[0]), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_clr", 64'(wr_err[0]), 64'd0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
